ex_wb_arbiter: RTL and testbench
================================

// Module: ex_wb_arbiter
// PURPOSE
//  Parametrised execution-result collector for NUM_CH execution units (ALU, Branch, MemAccess, ...).
//  Each channel pushes {result, rrf_tag, rrf_we} into its own DEPTH-entry FIFO using a valid/ready handshake.
//  A round-robin arbiter drains one entry per cycle onto a single registered writeback port feeding ROB/RRF.
//  Adds backpressure and pipeline flush, which the plain per-unit result latches lack.
// PARAMETERS
//  NUM_CH   3          number of execution channels (>=2)
//  DEPTH    2          entries per channel FIFO (power of two, >=2)
//  DATA_W   `DATA_LEN  result width
//  TAG_W    `RRF_SEL   RRF tag width
// PORTS
//  clk_i          in   1              clock, rising edge
//  reset_i        in   1              synchronous, active-high reset
//  flush_i        in   1              synchronous pipeline flush (mispredict)
//  ch_valid_i     in   NUM_CH         channel i presents a result
//  ch_ready_o     out  NUM_CH         channel i FIFO can accept
//  ch_data_i      in   NUM_CH*DATA_W  results; channel i at [i*DATA_W +: DATA_W]
//  ch_tag_i       in   NUM_CH*TAG_W   RRF tags; channel i at [i*TAG_W +: TAG_W]
//  ch_rrf_we_i    in   NUM_CH         result writes RRF
//  wb_result_o    out  DATA_W         writeback data
//  wb_rrf_tag_o   out  TAG_W          writeback tag
//  wb_rob_we_o    out  1              one-cycle pulse: ROB completion
//  wb_rrf_we_o    out  1              one-cycle pulse: RRF write (= rob_we & stored rrf_we)
//  wb_ch_o        out  $clog2(NUM_CH) source channel of current writeback
// BEHAVIOUR
//  - Reset: all FIFOs empty, rr_ptr=0, every output register 0 (wb_* = 0). ch_ready_o = all 1s the following cycle.
//  - ch_ready_o[i] = (count[i] != DEPTH), decoded from registered count only; no dependence on same-cycle pop.
//  - Push: ch_valid_i[i] & ch_ready_o[i] at an edge writes the tail and advances wr_ptr modulo DEPTH.
//  - A full FIFO refuses the push even when it is popped in the same cycle.
//  - Arbiter: grant = first channel with count!=0, scanning rr_ptr, rr_ptr+1, ... (mod NUM_CH).
//  - On grant: head popped; wb_result_o/wb_rrf_tag_o/wb_ch_o load the entry; wb_rob_we_o<=1; wb_rrf_we_o<=entry rrf_we.
//  - After a grant, rr_ptr <= (grant+1) mod NUM_CH.
//  - No grant: wb_rob_we_o<=0, wb_rrf_we_o<=0; wb_result_o/wb_rrf_tag_o/wb_ch_o hold their values; rr_ptr holds.
//  - Latency: push sampled at edge E0 into an empty, uncontested FIFO -> wb_rob_we_o high after edge E1 for exactly one cycle.
//  - Simultaneous push and pop on the same non-full FIFO: count unchanged, order preserved (FIFO per channel).
//  - Peak throughput: one writeback per cycle total. With all channels busy, each channel gets 1 of every NUM_CH slots.
//  - flush_i (priority over push/pop):
//      - next cycle: all counts and pointers 0, rr_ptr 0, wb_rob_we_o/wb_rrf_we_o 0; data/tag/ch hold
//      - pushes in the flush cycle are dropped
//  - reset_i has priority over flush_i. Mid-operation reset discards all entries, with no writeback pulse afterwards.
//  - Pointers use $clog2(DEPTH) bits and wrap naturally. Counts use $clog2(DEPTH)+1 bits.
// CONFIGURATION
//  EX_WB_STALL_CNT_EN defined:
//    - adds output stall_cnt_o [31:0]
//    - increments once per cycle in which any ch_valid_i[i] & !ch_ready_o[i]
//    - saturates at 32'hFFFF_FFFF
//    - cleared by reset_i only, not by flush_i
//  EX_WB_STALL_CNT_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//  1 Single push ch1 data=0x1234 tag=5 rrf_we=1 at E0 -> after E1: wb_result_o=0x1234, tag=5, wb_ch_o=1, rob_we=rrf_we=1 for 1 cycle.
//  2 All 3 channels push at E0 (data 0xA,0xB,0xC), rr_ptr=0 -> writebacks after E1,E2,E3 in order ch0,ch1,ch2; then rob_we=0.
//  3 ch0 pushes every cycle while ch1,ch2 are busy (DEPTH=2):
//      - ch_ready_o[0] falls once count=2
//      - a held valid is accepted only after a pop
//      - no entry lost or duplicated
//      - stall_cnt_o counts the refused cycles (with EX_WB_STALL_CNT_EN)
//  4 Two entries queued per channel, flush_i asserted one cycle together with a ch2 push:
//      - no writeback after the flush edge, and the ch2 push is dropped
//      - ch_ready_o=3'b111 next cycle
//      - a new push afterwards writes back normally with rr_ptr=0 arbitration
//  5 reset_i asserted mid-stream with FIFOs non-empty -> all wb_* = 0 next cycle, no further rob_we pulses, stall_cnt_o=0.
//  6 ch1 push with rrf_we=0 (store) -> wb_rob_we_o=1, wb_rrf_we_o=0 in the same cycle.

Source files
------------

// File: rtl/ex_wb_arbiter.sv
// ex_wb_arbiter: per-channel result FIFOs drained round-robin onto one registered writeback port.
// Optional stall counter output stall_cnt_o is present when EX_WB_STALL_CNT_EN is defined.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif

module ex_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;

  // Storage is not reset; only entries covered by r_count are ever observed.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

module ex_wb_arbiter #(
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 2,
  parameter int DATA_W = `DATA_LEN,
  parameter int TAG_W  = `RRF_SEL
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [NUM_CH-1:0]         ch_valid_i,
  output logic [NUM_CH-1:0]         ch_ready_o,
  input  logic [NUM_CH*DATA_W-1:0]  ch_data_i,
  input  logic [NUM_CH*TAG_W-1:0]   ch_tag_i,
  input  logic [NUM_CH-1:0]         ch_rrf_we_i,
  output logic [DATA_W-1:0]         wb_result_o,
  output logic [TAG_W-1:0]          wb_rrf_tag_o,
  output logic                      wb_rob_we_o,
  output logic                      wb_rrf_we_o,
  output logic [$clog2(NUM_CH)-1:0] wb_ch_o
`ifdef EX_WB_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int EW    = DATA_W + TAG_W + 1;

  logic [NUM_CH-1:0][CNT_W-1:0] w_count;
  logic [NUM_CH-1:0][EW-1:0]    w_head;
  logic [NUM_CH-1:0]            w_push, w_pop, w_nempty;
  logic [CH_W-1:0]              r_rr_ptr, w_gnt;
  logic                         w_gnt_vld;
  logic [EW-1:0]                w_gnt_ent;
  int                           w_idx;

  // Ready comes from the registered count only, so a full FIFO refuses even when popped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_ready_o[g] = (w_count[g] != CNT_W'(DEPTH));
    assign w_nempty[g]   = |w_count[g];
    assign w_push[g]     = ch_valid_i[g] & ch_ready_o[g] & ~flush_i & ~reset_i;
    assign w_pop[g]      = w_gnt_vld & (w_gnt == CH_W'(g)) & ~flush_i & ~reset_i;

    ex_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .i_clk   (clk_i),
      .i_rst   (reset_i),
      .i_flush (flush_i),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_din   ({ch_rrf_we_i[g], ch_tag_i[g*TAG_W +: TAG_W], ch_data_i[g*DATA_W +: DATA_W]}),
      .o_head  (w_head[g]),
      .o_count (w_count[g])
    );
  end

  // Scan from the far end so the channel closest to r_rr_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (w_nempty[CH_W'(w_idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CH_W'(w_idx);
      end
    end
  end

  assign w_gnt_ent = w_head[w_gnt];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rr_ptr     <= '0;
      wb_result_o  <= '0;
      wb_rrf_tag_o <= '0;
      wb_ch_o      <= '0;
      wb_rob_we_o  <= 1'b0;
      wb_rrf_we_o  <= 1'b0;
    end else if (flush_i) begin
      r_rr_ptr    <= '0;
      wb_rob_we_o <= 1'b0;
      wb_rrf_we_o <= 1'b0;
    end else if (w_gnt_vld) begin
      wb_result_o  <= w_gnt_ent[DATA_W-1:0];
      wb_rrf_tag_o <= w_gnt_ent[DATA_W +: TAG_W];
      wb_ch_o      <= w_gnt;
      wb_rob_we_o  <= 1'b1;
      wb_rrf_we_o  <= w_gnt_ent[EW-1];
      r_rr_ptr     <= (w_gnt == CH_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
    end else begin
      wb_rob_we_o <= 1'b0;
      wb_rrf_we_o <= 1'b0;
    end
  end

`ifdef EX_WB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Flush does not clear this: it tracks producer stalls across mispredicts.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_stall_cnt <= '0;
    else if (|(ch_valid_i & ~ch_ready_o) && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Randomized and directed bench for ex_wb_arbiter against a queue-level reference model.
module tb_ex_wb_arbiter;
  localparam int N  = 3;
  localparam int D  = 2;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int EW = DW + TW + 1;
  localparam int VW = N + 2 + 2 + TW + DW;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [N-1:0]    valid, ready, rrf_we;
  logic [N*DW-1:0] data;
  logic [N*TW-1:0] tag;
  logic [DW-1:0]   wb_res;
  logic [TW-1:0]   wb_tag;
  logic            rob_we, rrf_we_o;
  logic [1:0]      wb_ch;
`ifdef EX_WB_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  ex_wb_arbiter #(.NUM_CH(N), .DEPTH(D), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .flush_i      (flush),
    .ch_valid_i   (valid),
    .ch_ready_o   (ready),
    .ch_data_i    (data),
    .ch_tag_i     (tag),
    .ch_rrf_we_i  (rrf_we),
    .wb_result_o  (wb_res),
    .wb_rrf_tag_o (wb_tag),
    .wb_rob_we_o  (rob_we),
    .wb_rrf_we_o  (rrf_we_o),
    .wb_ch_o      (wb_ch)
`ifdef EX_WB_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  wire [VW-1:0] dut_vec = {ready, rob_we, rrf_we_o, wb_ch, wb_tag, wb_res};

  // Reference model: per-channel arrays kept in arrival order, plus expected output registers.
  logic [EW-1:0] mq [N][D];
  int            mcnt [N];
  int            m_rr;
  logic          e_rob, e_rrf;
  logic [DW-1:0] e_res;
  logic [TW-1:0] e_tag;
  logic [1:0]    e_ch;
  logic [31:0]   e_stall;
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mcnt[i] < D);
    return {r, e_rob, e_rrf, e_ch, e_tag, e_res};
  endfunction

  task automatic model_step();
    logic [N-1:0]  rdy;
    logic [EW-1:0] e;
    int            g;
    for (int i = 0; i < N; i++) rdy[i] = (mcnt[i] < D);
    if (rst) begin
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      m_rr = 0; e_rob = 0; e_rrf = 0; e_res = '0; e_tag = '0; e_ch = '0; e_stall = '0;
      return;
    end
    if ((valid & ~rdy) != '0 && e_stall != 32'hFFFF_FFFF) e_stall = e_stall + 1;
    if (flush) begin
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      m_rr = 0; e_rob = 0; e_rrf = 0;
      return;
    end
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && mcnt[(m_rr + k) % N] > 0) g = (m_rr + k) % N;
    if (g >= 0) begin
      e = mq[g][0];
      for (int j = 0; j < D - 1; j++) mq[g][j] = mq[g][j+1];
      mcnt[g]--;
      e_res = e[DW-1:0]; e_tag = e[DW +: TW]; e_rrf = e[EW-1]; e_rob = 1'b1;
      e_ch = 2'(g);
      m_rr = (g + 1) % N;
    end else begin
      e_rob = 1'b0; e_rrf = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (valid[i] && rdy[i]) begin
        mq[i][mcnt[i]] = {rrf_we[i], tag[i*TW +: TW], data[i*DW +: DW]};
        mcnt[i]++;
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ch(input int c, input logic [DW-1:0] d, input logic [TW-1:0] t, input logic we);
    valid[c] = 1'b1; data[c*DW +: DW] = d; tag[c*TW +: TW] = t; rrf_we[c] = we;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; valid = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; valid = '0; data = '0; tag = '0; rrf_we = '0;
    cyc(); cyc();
    vectors++;
    if (dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL reset_vec: got %h want %h", dut_vec, exp_vec());
    end
    vectors++;
    if ({rob_we, rrf_we_o, wb_ch, wb_tag, wb_res} !== '0) begin
      miscompares++; $display("FAIL reset_wb_zero: got %h want 0", {rob_we, rrf_we_o, wb_ch, wb_tag, wb_res});
    end
    rst = 1'b0;
    cyc();
    vectors++;
    if (ready !== 3'b111) begin
      miscompares++; $display("FAIL reset_ready: got %b want 111", ready);
    end
`ifdef EX_WB_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 32'd0) begin
      miscompares++; $display("FAIL reset_stall: got %0d want 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_single();
    set_ch(1, 32'h1234, 6'd5, 1'b1);
    cyc();
    valid = '0;
    vectors++;
    if (rob_we !== 1'b0 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL single_e0: got %h want %h", dut_vec, exp_vec());
    end
    cyc();
    vectors++;
    if ({rob_we, rrf_we_o, wb_ch, wb_tag, wb_res} !== {1'b1, 1'b1, 2'd1, 6'd5, 32'h1234} ||
        dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL single_e1: got %h want %h", dut_vec, exp_vec());
    end
    cyc();
    vectors++;
    if (rob_we !== 1'b0 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL single_e2: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_all_three();
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 32'hA + DW'(c), 6'(c + 1), 1'b1);
    cyc();
    valid = '0;
    for (int k = 0; k < N; k++) begin
      cyc();
      vectors++;
      if (rob_we !== 1'b1 || wb_ch !== 2'(k) || wb_res !== 32'hA + DW'(k) || dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL all3_wb%0d: got %h want %h", k, dut_vec, exp_vec());
      end
    end
    cyc();
    vectors++;
    if (rob_we !== 1'b0 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL all3_idle: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_backpressure();
    int seq = 0, wb_seq = 0;
    bit acc;
    do_reset();
    set_ch(0, 32'h100, 6'd0, 1'b1);
    for (int t = 0; t < 30; t++) begin
      if (t < 20) begin
        set_ch(1, $urandom, 6'($urandom), 1'b1);
        set_ch(2, $urandom, 6'($urandom), 1'b0);
      end else begin
        valid = '0;
      end
      acc = valid[0] && (mcnt[0] < D);
      cyc();
      if (acc) seq++;
      if (t < 20) set_ch(0, 32'h100 + DW'(seq), 6'(seq), 1'b1);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL bp_cyc%0d: got %h want %h", t, dut_vec, exp_vec());
      end
      if (rob_we === 1'b1 && wb_ch === 2'd0) begin
        vectors++;
        if (wb_res !== 32'h100 + DW'(wb_seq)) begin
          miscompares++; $display("FAIL bp_order: got %h want %h", wb_res, 32'h100 + DW'(wb_seq));
        end
        wb_seq++;
      end
    end
    vectors++;
    if (wb_seq !== seq) begin
      miscompares++; $display("FAIL bp_count: got %0d writebacks want %0d", wb_seq, seq);
    end
`ifdef EX_WB_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== e_stall || stall_cnt == 32'd0) begin
      miscompares++; $display("FAIL bp_stall: got %0d want %0d", stall_cnt, e_stall);
    end
`endif
  endtask

  task automatic test_flush();
    logic [DW-1:0] hold_res;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < N; c++) set_ch(c, 32'h200 + DW'(t * 4 + c), 6'(c), 1'b1);
      cyc();
    end
    valid = '0;
    set_ch(2, 32'hDEAD, 6'd9, 1'b1);
    flush = 1'b1;
    hold_res = wb_res;
    cyc();
    flush = 1'b0; valid = '0;
    vectors++;
    if (rob_we !== 1'b0 || ready !== 3'b111 || wb_res !== hold_res || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL flush_edge: got %h want %h", dut_vec, exp_vec());
    end
    cyc();
    vectors++;
    if (rob_we !== 1'b0 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL flush_drop: got %h want %h", dut_vec, exp_vec());
    end
    set_ch(2, 32'h22, 6'd2, 1'b1);
    set_ch(1, 32'h11, 6'd1, 1'b1);
    cyc();
    valid = '0;
    cyc();
    vectors++;
    if (rob_we !== 1'b1 || wb_ch !== 2'd1 || wb_res !== 32'h11 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL flush_rr1: got %h want %h", dut_vec, exp_vec());
    end
    cyc();
    vectors++;
    if (rob_we !== 1'b1 || wb_ch !== 2'd2 || wb_res !== 32'h22 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL flush_rr2: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < N; c++) set_ch(c, $urandom, 6'($urandom), 1'b1);
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0; valid = '0;
    vectors++;
    if ({rob_we, rrf_we_o, wb_ch, wb_tag, wb_res} !== '0 || ready !== 3'b111) begin
      miscompares++; $display("FAIL rstmid_zero: got %h want %h", dut_vec, {3'b111, {(VW-N){1'b0}}});
    end
`ifdef EX_WB_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 32'd0) begin
      miscompares++; $display("FAIL rstmid_stall: got %0d want 0", stall_cnt);
    end
`endif
    for (int t = 0; t < 4; t++) begin
      cyc();
      vectors++;
      if (rob_we !== 1'b0 || dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL rstmid_quiet%0d: got %h want %h", t, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_store();
    do_reset();
    set_ch(1, 32'h55, 6'd3, 1'b0);
    cyc();
    valid = '0;
    cyc();
    vectors++;
    if (rob_we !== 1'b1 || rrf_we_o !== 1'b0 || wb_ch !== 2'd1 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL store: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 99) < 3);
      valid = N'($urandom);
      for (int c = 0; c < N; c++) begin
        data[c*DW +: DW] = $urandom;
        tag[c*TW +: TW]  = 6'($urandom);
      end
      rrf_we = N'($urandom);
      cyc();
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL rand_cyc%0d: got %h want %h", t, dut_vec, exp_vec());
      end
`ifdef EX_WB_STALL_CNT_EN
      vectors++;
      if (stall_cnt !== e_stall) begin
        miscompares++; $display("FAIL rand_stall%0d: got %0d want %0d", t, stall_cnt, e_stall);
      end
`endif
    end
    rst = 1'b0; flush = 1'b0; valid = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid = '0; data = '0; tag = '0; rrf_we = '0;
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    m_rr = 0; e_rob = 0; e_rrf = 0; e_res = '0; e_tag = '0; e_ch = '0; e_stall = '0;
    test_reset();
    test_single();
    test_all_three();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_store();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
